prime_lister: RTL and testbench

- Downstream consumer of the sieve stage.
- Takes the sieve's flat prime bitmap (bit k set means number START+k is prime) and walks it from the lowest index to the highest.
- Emits each prime's numeric value, one per transfer, on a valid/ready stream.
- Keeps a running prime count and flags completion. It feeds the display/UART formatting stages that cannot accept a 10000-bit vector.

---
 rtl/prime_lister.sv | 117 +++++++++++
 tb/tb_prime_lister.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_lister.sv
// prime_lister: walks the sieve's prime bitmap from bit 0 upward and streams the value of
// each set bit over a valid/ready handshake, counting accepted primes since the last start.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   SCAN  | examining bitmap bit idx, one bit per cycle
//   OUT   | presenting START+idx until the consumer accepts it
//   DONE  | scan finished, done held high until the next start
module prime_lister #(
  parameter int RANGE   = 10000,
  parameter int START   = 100,
  parameter int IDX_W   = 14,
  parameter int VALUE_W = 14,
  parameter int CNT_W   = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RANGE-1:0]   sieve_vec,
  input  logic               start,
  output logic [VALUE_W-1:0] prime_value,
  output logic               prime_valid,
  input  logic               prime_ready,
  output logic [CNT_W-1:0]   prime_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RANGE - 1);
  // Bits standing for the numbers 0 and 1 can never be prime, whatever the sieve says.
  localparam logic [RANGE-1:0] LOW_MASK = (START <= 0) ? RANGE'(3) :
                                          (START == 1) ? RANGE'(1) : '0;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [RANGE-1:0]   masked_vec;
  logic               cur_bit;

  always_comb begin
    masked_vec = sieve_vec & ~LOW_MASK;
    cur_bit    = |(masked_vec & (RANGE'(1) << idx_q));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
          count_d = '0;
        end
      end
      S_SCAN: begin
        if (cur_bit) begin
          value_d = VALUE_W'(START) + VALUE_W'(idx_q);
          valid_d = 1'b1;
          state_d = S_OUT;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_OUT: begin
        if (prime_ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign prime_value = value_q;
  assign prime_valid = valid_q;
  assign prime_count = count_q;
  assign busy        = (state_q == S_SCAN) || (state_q == S_OUT);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_prime_lister.sv
// Bench for prime_lister: a 16-bit START=0 instance and a default-size instance, each
// checked against a bitmap-walk reference model and a golden trial-division prime list.
module tb_prime_lister;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] s_vec;
  logic        s_start, s_ready, s_valid, s_busy, s_done;
  logic [4:0]  s_value, s_count;

  logic [9999:0] l_vec;
  logic          l_start, l_ready, l_valid, l_busy, l_done;
  logic [13:0]   l_value, l_count;

  prime_lister #(.RANGE(16), .START(0), .IDX_W(5), .VALUE_W(5), .CNT_W(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .sieve_vec(s_vec), .start(s_start),
    .prime_value(s_value), .prime_valid(s_valid), .prime_ready(s_ready),
    .prime_count(s_count), .busy(s_busy), .done(s_done));

  prime_lister dut_l (
    .clk(clk), .rst_n(rst_n), .sieve_vec(l_vec), .start(l_start),
    .prime_value(l_value), .prime_valid(l_valid), .prime_ready(l_ready),
    .prime_count(l_count), .busy(l_busy), .done(l_done));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors sample on the falling edge; edges are numbered by cyc.
  int   s_acc[$], s_rise[$];
  int   s_done_edge, s_sedge, s_hold_viol, s_b2b_viol;
  bit   s_done_seen;
  logic s_pv = 1'b0, s_pr = 1'b0, s_pd = 1'b0;
  logic [4:0] s_pval = '0;

  always @(negedge clk) begin
    if (s_valid && s_ready) s_acc.push_back(int'(s_value));
    if (s_valid && !s_pv) s_rise.push_back(cyc);
    if (rst_n && s_pv && !s_pr && (!s_valid || s_value != s_pval)) s_hold_viol++;
    if (s_pv && s_pr && s_valid) s_b2b_viol++;
    if (s_done && !s_pd) begin s_done_seen = 1; s_done_edge = cyc; end
    s_pv = s_valid; s_pr = s_ready; s_pd = s_done; s_pval = s_value;
  end

  int   l_acc[$];
  int   l_first_rise, l_done_edge, l_sedge, l_hold_viol, l_b2b_viol;
  bit   l_done_seen;
  logic l_pv = 1'b0, l_pr = 1'b0, l_pd = 1'b0;
  logic [13:0] l_pval = '0;

  always @(negedge clk) begin
    if (l_valid && l_ready) l_acc.push_back(int'(l_value));
    if (l_valid && !l_pv && l_first_rise < 0) l_first_rise = cyc;
    if (rst_n && l_pv && !l_pr && (!l_valid || l_value != l_pval)) l_hold_viol++;
    if (l_pv && l_pr && l_valid) l_b2b_viol++;
    if (l_done && !l_pd) begin l_done_seen = 1; l_done_edge = cyc; end
    l_pv = l_valid; l_pr = l_ready; l_pd = l_done; l_pval = l_value;
  end

  // Reference model: walk the bitmap; a clear bit costs one cycle, a set bit two (ready held high).
  int exp_q[$];
  int exp_first, exp_done_off;

  task automatic model_small(input logic [15:0] v);
    int t;
    t = 0; exp_first = -1; exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      if (v[k] && (0 + k) >= 2) begin
        exp_q.push_back(0 + k);
        if (exp_first < 0) exp_first = t + 1;
        t += 2;
      end else t += 1;
    end
    exp_done_off = t;
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  function automatic int s_diff();
    int n;
    n = (s_acc.size() < exp_q.size()) ? s_acc.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (s_acc[i] != exp_q[i]) return i;
    if (s_acc.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int l_diff();
    int n;
    n = (l_acc.size() < exp_q.size()) ? l_acc.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (l_acc[i] != exp_q[i]) return i;
    if (l_acc.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic s_pulse_start();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    s_sedge = cyc;
    s_acc.delete(); s_rise.delete();
    s_done_seen = 0; s_hold_viol = 0; s_b2b_viol = 0;
  endtask

  task automatic s_wait_done(input int budget, input int rmode, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      s_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (s_done_seen) begin ok = 1; break; end
    end
  endtask

  task automatic l_pulse_start();
    @(posedge clk); #1 l_start = 1'b1;
    @(posedge clk); #1 l_start = 1'b0;
    l_sedge = cyc;
    l_acc.delete(); l_first_rise = -1;
    l_done_seen = 0; l_hold_viol = 0; l_b2b_viol = 0;
  endtask

  task automatic l_wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      l_ready = 1'b1;
      if (l_done_seen) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_vec = '0; s_start = 0; s_ready = 0;
    l_vec = '0; l_start = 0; l_ready = 0;
    #12;
    checks++; if ({s_value, s_valid, s_count, s_busy, s_done} !== 13'd0) begin
      errors++; $display("FAIL reset_small: got %b, expected all zero", {s_value, s_valid, s_count, s_busy, s_done}); end
    checks++; if ({l_value, l_valid, l_count, l_busy, l_done} !== 31'd0) begin
      errors++; $display("FAIL reset_large: got %b, expected all zero", {l_value, l_valid, l_count, l_busy, l_done}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({s_busy, s_done, l_busy, l_done} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: busy/done got %b, expected 0000", {s_busy, s_done, l_busy, l_done}); end
  endtask

  task automatic test_basic();
    bit ok; int d;
    s_vec = 16'h28AF; s_ready = 1'b1; model_small(s_vec);
    s_pulse_start(); s_wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: done got 0, expected 1"); end
    d = s_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL basic_seq: got %0d values, diff at %0d, expected %0d values", s_acc.size(), d, exp_q.size()); end
    checks++; if (s_count !== 5'd6) begin errors++; $display("FAIL basic_count: got %0d expected 6", s_count); end
    checks++; if (s_rise.size() == 0 || s_rise[0] - s_sedge != exp_first) begin
      errors++; $display("FAIL basic_first_latency: got %0d expected %0d", (s_rise.size() == 0) ? -1 : s_rise[0] - s_sedge, exp_first); end
    checks++; if (s_done_edge - s_sedge != exp_done_off) begin
      errors++; $display("FAIL basic_done_latency: got %0d expected %0d", s_done_edge - s_sedge, exp_done_off); end
    checks++; if ({s_done, s_busy} !== 2'b10) begin errors++; $display("FAIL basic_done_busy: got %b expected 10", {s_done, s_busy}); end
    checks++; if (s_b2b_viol != 0 || s_hold_viol != 0) begin
      errors++; $display("FAIL basic_protocol: b2b %0d hold %0d, expected 0 0", s_b2b_viol, s_hold_viol); end
  endtask

  task automatic test_backpressure();
    bit stalled; int d;
    s_vec = 16'h28AF; s_ready = 1'b1; model_small(s_vec); stalled = 0;
    s_pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (s_valid && s_value == 5'd5 && !stalled) begin
        stalled = 1; s_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(posedge clk); #1;
          checks++; if (s_valid !== 1'b1 || s_value !== 5'd5 || s_count !== 5'd2) begin
            errors++; $display("FAIL stall_hold[%0d]: valid %b value %0d count %0d, expected 1 5 2", j, s_valid, s_value, s_count); end
        end
        s_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_count !== 5'd3 || s_valid !== 1'b0) begin
          errors++; $display("FAIL stall_accept: count %0d valid %b, expected 3 0", s_count, s_valid); end
      end
      if (s_done_seen) break;
    end
    checks++; if (!stalled || !s_done_seen) begin errors++; $display("FAIL bp_progress: stalled %0d done %0d, expected 1 1", stalled, s_done_seen); end
    d = s_diff();
    checks++; if (d != -1 || s_count !== 5'd6) begin
      errors++; $display("FAIL bp_seq: diff at %0d count %0d, expected -1 6", d, s_count); end
    checks++; if (s_hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d expected 0", s_hold_viol); end
  endtask

  task automatic test_empty();
    bit ok;
    s_vec = 16'h0000; s_ready = 1'b1;
    s_pulse_start(); s_wait_done(100, 0, ok);
    checks++; if (!ok || s_done_edge - s_sedge != 16) begin
      errors++; $display("FAIL empty_done_latency: got %0d expected 16", ok ? s_done_edge - s_sedge : -1); end
    checks++; if (s_rise.size() != 0 || s_count !== 5'd0) begin
      errors++; $display("FAIL empty_output: valid rises %0d count %0d, expected 0 0", s_rise.size(), s_count); end
  endtask

  task automatic test_top_bit();
    bit ok;
    s_vec = 16'h8000; s_ready = 1'b1; model_small(s_vec);
    s_pulse_start(); s_wait_done(100, 0, ok);
    checks++; if (!ok || s_acc.size() != 1 || s_acc[0] != 15) begin
      errors++; $display("FAIL top_bit_value: got %0d values (first %0d), expected one value 15", s_acc.size(), (s_acc.size() > 0) ? s_acc[0] : -1); end
    checks++; if (s_count !== 5'd1 || s_done_edge - s_sedge != exp_done_off) begin
      errors++; $display("FAIL top_bit_done: count %0d latency %0d, expected 1 %0d", s_count, s_done_edge - s_sedge, exp_done_off); end
  endtask

  task automatic test_random();
    bit ok; int d; logic [15:0] v;
    for (int it = 0; it < 20; it++) begin
      v = 16'($urandom); s_vec = v; s_ready = 1'b1; model_small(v);
      s_pulse_start(); s_wait_done(400, it % 2, ok);
      d = s_diff();
      checks++; if (!ok || d != -1) begin
        errors++; $display("FAIL rand_seq[%0d] vec %h: done %0d diff at %0d, got %0d values expected %0d", it, v, ok, d, s_acc.size(), exp_q.size()); end
      checks++; if (int'(s_count) != exp_q.size()) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", it, s_count, exp_q.size()); end
      checks++; if (s_hold_viol != 0 || s_b2b_viol != 0) begin
        errors++; $display("FAIL rand_protocol[%0d]: hold %0d b2b %0d, expected 0 0", it, s_hold_viol, s_b2b_viol); end
      if (it % 2 == 0) begin
        checks++; if (s_done_edge - s_sedge != exp_done_off) begin
          errors++; $display("FAIL rand_done_latency[%0d]: got %0d expected %0d", it, s_done_edge - s_sedge, exp_done_off); end
      end
    end
  endtask

  task automatic test_start_in_scan();
    bit ok; int d;
    s_vec = 16'h28AF; s_ready = 1'b1; model_small(s_vec);
    s_pulse_start();
    for (int p = 0; p < 2; p++) begin
      repeat (4) @(posedge clk);
      #1 s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
    end
    s_wait_done(200, 0, ok);
    d = s_diff();
    checks++; if (!ok || d != -1 || s_done_edge - s_sedge != exp_done_off) begin
      errors++; $display("FAIL start_in_scan: diff at %0d latency %0d, expected -1 %0d", d, s_done_edge - s_sedge, exp_done_off); end
    s_pulse_start();
    checks++; if (s_count !== 5'd0 || s_done !== 1'b0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL restart_from_done: count %0d done %b busy %b, expected 0 0 1", s_count, s_done, s_busy); end
    s_wait_done(200, 0, ok);
    d = s_diff();
    checks++; if (!ok || d != -1 || s_count !== 5'd6) begin
      errors++; $display("FAIL restart_seq: diff at %0d count %0d, expected -1 6", d, s_count); end
  endtask

  task automatic test_reset_mid();
    bit hit, ok; int d;
    s_vec = 16'h28AF; s_ready = 1'b1; model_small(s_vec); hit = 0;
    s_pulse_start();
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (s_valid && s_value == 5'd7) begin
        hit = 1; s_ready = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++; if ({s_value, s_valid, s_count, s_busy, s_done} !== 13'd0) begin
          errors++; $display("FAIL async_reset_outputs: got %b expected all zero", {s_value, s_valid, s_count, s_busy, s_done}); end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL reset_mid_reach7: value 7 never held, expected it"); end
    @(posedge clk); #1 rst_n = 1'b1; s_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if ({s_busy, s_done, s_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_idle: busy/done/valid got %b expected 000", {s_busy, s_done, s_valid}); end
    s_pulse_start(); s_wait_done(200, 0, ok);
    d = s_diff();
    checks++; if (!ok || d != -1 || s_count !== 5'd6) begin
      errors++; $display("FAIL reset_mid_rerun: diff at %0d count %0d, expected -1 6", d, s_count); end
  endtask

  task automatic test_large_latency();
    bit ok;
    l_vec = '0; l_vec[0] = 1'b1; l_ready = 1'b1;
    l_pulse_start(); l_wait_done(12000, ok);
    checks++; if (l_first_rise - l_sedge != 1) begin
      errors++; $display("FAIL large_first_latency: got %0d expected 1", l_first_rise - l_sedge); end
    checks++; if (!ok || l_acc.size() != 1 || l_acc[0] != 100 || l_done_edge - l_sedge != 10001) begin
      errors++; $display("FAIL large_bit0: done %0d values %0d latency %0d, expected 1 one value 100 latency 10001", ok, l_acc.size(), l_done_edge - l_sedge); end
  endtask

  task automatic test_large_golden();
    bit ok; int d, incr_viol;
    exp_q.delete();
    for (int k = 0; k < 10000; k++) begin
      l_vec[k] = is_prime(100 + k);
      if (l_vec[k]) exp_q.push_back(100 + k);
    end
    l_ready = 1'b1;
    l_pulse_start(); l_wait_done(12000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL large_timeout: done got 0 expected 1"); end
    checks++; if (l_count !== 14'd1215 || exp_q.size() != 1215) begin
      errors++; $display("FAIL large_count: got %0d (model %0d) expected 1215", l_count, exp_q.size()); end
    checks++; if (l_acc.size() == 0 || l_acc[0] != 101 || l_acc[l_acc.size()-1] != 10099) begin
      errors++; $display("FAIL large_ends: got %0d values, expected first 101 last 10099", l_acc.size()); end
    incr_viol = 0;
    for (int i = 1; i < l_acc.size(); i++) if (l_acc[i] <= l_acc[i-1]) incr_viol++;
    checks++; if (incr_viol != 0) begin errors++; $display("FAIL large_increasing: got %0d violations expected 0", incr_viol); end
    d = l_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL large_seq: diff at %0d, got %0d values expected %0d", d, l_acc.size(), exp_q.size()); end
    checks++; if (l_done_edge - l_sedge != 11215 || l_b2b_viol != 0 || l_hold_viol != 0) begin
      errors++; $display("FAIL large_timing: latency %0d b2b %0d hold %0d, expected 11215 0 0", l_done_edge - l_sedge, l_b2b_viol, l_hold_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_top_bit();
    test_random();
    test_start_in_scan();
    test_reset_mid();
    test_large_latency();
    test_large_golden();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
